sqrt_arbiter: RTL and testbench
===============================

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter LATENCY, default 12, giving the shared sqrt pipeline depth in cycles (vld in to vld out).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port en_i, input, 1: grant enable; low drains the pipeline.
REQ-006 SHALL have port req_vld_i, input, NUM_REQ: per-requester request valid.
REQ-007 SHALL have port req_data_i, input, NUM_REQ*16: per-requester operand; slice i = bits [16*i+15:16*i].
REQ-008 SHALL have port req_rdy_o, input-side output, NUM_REQ: per-requester accept.
REQ-009 SHALL have port sqrt_data_o, output, 16: operand to the shared sqrt unit.
REQ-010 SHALL have port sqrt_vld_o, output, 1: operand valid to the sqrt unit.
REQ-011 SHALL have port sqrt_data_i, input, 12: result from the sqrt unit.
REQ-012 SHALL have port sqrt_vld_i, input, 1: result valid from the sqrt unit.
REQ-013 SHALL have port rsp_vld_o, output, NUM_REQ: one-hot result valid per requester; no backpressure.
REQ-014 SHALL have port rsp_data_o, output, 12: result, shared by all requesters.
REQ-015 SHALL have port idle_o, output, 1: high when in IDLE state.
REQ-016 SHALL have port err_o, output, 1: sticky tag/valid mismatch flag.

Function
REQ-017 SHALL accept request i in a cycle only when req_vld_i[i] and req_rdy_o[i] are both high; requesters hold valid and data until accepted.
REQ-018 SHALL assert at most one req_rdy_o bit per cycle, chosen round-robin starting from the pointer; req_rdy_o is combinational from req_vld_i, the pointer and the state.
REQ-019 SHALL set the pointer to (i+1) mod NUM_REQ after granting i, and leave it unchanged when there is no grant.
REQ-020 SHALL register the accepted operand so that sqrt_vld_o/sqrt_data_o appear one cycle after acceptance; with no grant, sqrt_vld_o=0 and sqrt_data_o holds its last value.
REQ-021 SHALL carry {valid, requester index} through a (LATENCY+1)-deep tag shift register aligned with the sqrt pipeline.
REQ-022 SHALL register the response: on the cycle after sqrt_vld_i with a valid tag, rsp_vld_o is one-hot at the tag index and rsp_data_o = sqrt_data_i; total latency from acceptance to response = LATENCY+2.
REQ-023 SHALL sustain one acceptance per cycle, with back-to-back grants to different requesters or to the same one.
REQ-024 SHALL use states IDLE (en_i low, no tags in flight), RUN (grants allowed) and DRAIN (en_i low, tags in flight, no grants).
REQ-025 SHALL use these transitions: IDLE->RUN when en_i=1; RUN->DRAIN when en_i=0 and tags are in flight; RUN->IDLE when en_i=0 and no tags are in flight; DRAIN->IDLE when the tag register is empty; DRAIN->RUN when en_i=1.
REQ-026 SHALL grant only in RUN; a request arriving in the same cycle as en_i falling is not granted.

Reset
REQ-027 SHALL reset the state to IDLE and clear the pointer (to 0), the tag register, sqrt_vld_o, rsp_vld_o and err_o; sqrt_data_o and rsp_data_o reset to 0; idle_o=1.
REQ-028 SHALL discard all in-flight tags on reset mid-operation; sqrt results arriving afterwards produce no rsp_vld_o and do not set err_o.

Configuration
REQ-029 SHALL include the tag check when SQRT_ARB_ERRCHK_EN is defined: err_o is set when sqrt_vld_i differs from the tag valid bit (excluding the post-reset window of LATENCY+1 cycles); once set, err_o stays set until rst.
REQ-030 SHALL tie err_o to 0 and include no check logic when SQRT_ARB_ERRCHK_EN is undefined.

Structure
REQ-031 SHALL take SQRT_IN_W=16, SQRT_OUT_W=12, SQRT_LAT=12 and the state enum from shared package sqrt_arb_pkg.
REQ-032 SHALL implement the grant logic in sub-module rr_arbiter (parameter N; inputs req, ptr, en; output one-hot gnt).

Verification (bench uses the 16-bit-in/12-bit-out sqrt unit with zero offset)
REQ-033 SHALL cover: requester 0 sends 0x0010 -> rsp_vld_o=0001 and rsp_data_o=0x040, 14 cycles after acceptance.
REQ-034 SHALL cover: all 4 requesters valid continuously, pointer at 0 -> grants in order 0,1,2,3,0...; responses return in the same order, one per cycle.
REQ-035 SHALL cover: requester 2 sends 0xFFFF then 0x0000 back-to-back -> rsp_data_o=0xFFF then 0x000, both on bit 2.
REQ-036 SHALL cover: en_i dropped with 5 results in flight -> state goes to DRAIN, no grants, all 5 responses delivered, idle_o=1 one cycle after the last tag leaves.
REQ-037 SHALL cover: rst asserted with results in flight -> no rsp_vld_o afterwards, and err_o=0.
REQ-038 SHALL cover, with SQRT_ARB_ERRCHK_EN: force a spurious sqrt_vld_i with no tag -> err_o=1 and stays 1 until rst.

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
// Shared widths, FSM state type and tag payload for the sqrt arbiter.
package sqrt_arb_pkg;

  localparam int unsigned SQRT_IN_W  = 16;
  localparam int unsigned SQRT_OUT_W = 12;
  localparam int unsigned SQRT_LAT   = 12;
  localparam int unsigned TAG_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Sized for the largest requester count (8), so it is independent of NUM_REQ.
  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: the first requester at or after ptr wins; no grant when en is low.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;

  // Scan from the farthest slot down to ptr so the closest requester is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    if (en) begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        idx = PW'((32'(ptr) + 32'(k)) % N);
        if (req[idx]) gnt = N'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one pipelined sqrt unit among NUM_REQ requesters; tags track each result's owner.
// Define SQRT_ARB_ERRCHK_EN to enable the sticky tag/valid mismatch check on err_o.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = SQRT_LAT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_i,
  input  logic [NUM_REQ-1:0]             req_vld_i,
  input  logic [NUM_REQ*SQRT_IN_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  output logic [SQRT_IN_W-1:0]           sqrt_data_o,
  output logic                           sqrt_vld_o,
  input  logic [SQRT_OUT_W-1:0]          sqrt_data_i,
  input  logic                           sqrt_vld_i,
  output logic [NUM_REQ-1:0]             rsp_vld_o,
  output logic [SQRT_OUT_W-1:0]          rsp_data_o,
  output logic                           idle_o,
  output logic                           err_o
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     gnt;
  logic                   arb_en;
  logic [PW-1:0]          gnt_idx;
  logic [SQRT_IN_W-1:0]   gnt_data;
  logic                   inflight;
  tag_t                   tag_q [LATENCY+1];
  logic                   sqrt_vld_q;
  logic [SQRT_IN_W-1:0]   sqrt_data_q;
  logic [NUM_REQ-1:0]     rsp_vld_q;
  logic [SQRT_OUT_W-1:0]  rsp_data_q;
  logic                   idle_q;
  logic                   rsp_hit;

  assign arb_en = (state_q == RUN) && en_i;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_vld_i),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign req_rdy_o = gnt;

  // Encode the one-hot grant and select the winning operand.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PW'(i);
        gnt_data = req_data_i[i*SQRT_IN_W +: SQRT_IN_W];
      end
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int unsigned k = 0; k <= LATENCY; k++) inflight = inflight | tag_q[k].vld;
  end

  // Next state and round-robin pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (!en_i) state_d = inflight ? DRAIN : IDLE;
      DRAIN: begin
        if (en_i)           state_d = RUN;
        else if (!inflight) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (|gnt) ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
  end

  assign rsp_hit = sqrt_vld_i && tag_q[LATENCY].vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sqrt_vld_q  <= 1'b0;
      sqrt_data_q <= '0;
      rsp_vld_q   <= '0;
      rsp_data_q  <= '0;
      idle_q      <= 1'b1;
      for (int unsigned k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idle_q     <= (state_d == IDLE);
      sqrt_vld_q <= |gnt;
      if (|gnt) sqrt_data_q <= gnt_data;
      tag_q[0]   <= tag_t'{vld: |gnt, idx: TAG_IDX_W'(gnt_idx)};
      for (int unsigned k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
      rsp_vld_q  <= rsp_hit ? (NUM_REQ'(1) << tag_q[LATENCY].idx) : '0;
      if (rsp_hit) rsp_data_q <= sqrt_data_i;
    end
  end

  assign sqrt_vld_o  = sqrt_vld_q;
  assign sqrt_data_o = sqrt_data_q;
  assign rsp_vld_o   = rsp_vld_q;
  assign rsp_data_o  = rsp_data_q;
  assign idle_o      = idle_q;

`ifdef SQRT_ARB_ERRCHK_EN
  localparam int unsigned MW = $clog2(LATENCY + 2);

  logic [MW-1:0] mask_q;
  logic          err_q;

  // Results issued before reset may still emerge; ignore the first LATENCY+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= MW'(LATENCY + 1);
      err_q  <= 1'b0;
    end else if (mask_q != '0) begin
      mask_q <= mask_q - MW'(1);
    end else if (sqrt_vld_i != tag_q[LATENCY].vld) begin
      err_q  <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter with a 12-stage sqrt model (out = isqrt(in << 8)).
module tb_sqrt_arbiter;
  import sqrt_arb_pkg::*;

  localparam int unsigned NR      = 4;
  localparam int unsigned LAT     = SQRT_LAT;
  localparam int unsigned RSP_LAT = LAT + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en_i = 1'b0;
  logic [NR-1:0]     req_vld_i = '0;
  logic [NR*16-1:0]  req_data_i = '0;
  logic [NR-1:0]     req_rdy_o;
  logic [15:0]       sqrt_data_o;
  logic              sqrt_vld_o;
  logic [11:0]       sqrt_data_i;
  logic              sqrt_vld_i;
  logic [NR-1:0]     rsp_vld_o;
  logic [11:0]       rsp_data_o;
  logic              idle_o;
  logic              err_o;
  logic              spur = 1'b0;

  sqrt_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .req_vld_i  (req_vld_i),
    .req_data_i (req_data_i),
    .req_rdy_o  (req_rdy_o),
    .sqrt_data_o(sqrt_data_o),
    .sqrt_vld_o (sqrt_vld_o),
    .sqrt_data_i(sqrt_data_i),
    .sqrt_vld_i (sqrt_vld_i),
    .rsp_vld_o  (rsp_vld_o),
    .rsp_data_o (rsp_data_o),
    .idle_o     (idle_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] isqrt(input logic [15:0] x);
    logic [31:0] v;
    logic [31:0] t;
    logic [11:0] r;
    v = {8'h00, x, 8'h00};
    r = '0;
    for (int b = 11; b >= 0; b--) begin
      t = 32'(r | (12'd1 << b));
      if (t * t <= v) r = t[11:0];
    end
    return r;
  endfunction

  // External sqrt unit: not reset, so results in flight survive a DUT reset.
  logic        pv [LAT] = '{default: 1'b0};
  logic [11:0] pd [LAT] = '{default: 12'h000};
  always @(posedge clk) begin
    pv[0] <= sqrt_vld_o;
    pd[0] <= isqrt(sqrt_data_o);
    for (int k = 1; k < int'(LAT); k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
  end
  assign sqrt_vld_i  = pv[LAT-1] | spur;
  assign sqrt_data_i = pd[LAT-1];

  typedef struct packed {
    logic [31:0] idx;
    logic [11:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t         sb [$];
  logic [15:0]  src_q [NR][$];
  int unsigned  acc_idx_log [$];
  int unsigned  acc_cyc_log [$];
  logic [11:0]  rsp_data_log [$];
  logic [NR-1:0] rsp_vld_log [$];
  int unsigned  cyc = 0;
  int unsigned  rsp_cnt = 0;
  logic         last_idle = 1'b0;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: monitor/scoreboard at negedge, then drive requesters after the posedge.
  task automatic tick();
    logic [NR-1:0] acc;
    exp_t e;
    @(negedge clk);
    acc = rst ? '0 : (req_vld_i & req_rdy_o);
    if (rst) begin
      sb.delete();
    end else begin
      chk("rdy_legal", 32'(($countones(req_rdy_o) <= 1) && ((req_rdy_o & ~req_vld_i) == '0)), 32'd1);
      for (int i = 0; i < int'(NR); i++) begin
        if (acc[i]) begin
          sb.push_back(exp_t'{32'(i), isqrt(req_data_i[i*16 +: 16]), cyc});
          acc_idx_log.push_back(i);
          acc_cyc_log.push_back(cyc);
        end
      end
      if (rsp_vld_o != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_vld_o), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_onehot", 32'(rsp_vld_o), 32'd1 << e.idx);
          chk("rsp_data", 32'(rsp_data_o), 32'(e.data));
          chk("rsp_latency", cyc - e.cyc, RSP_LAT);
        end
        rsp_cnt++;
        rsp_data_log.push_back(rsp_data_o);
        rsp_vld_log.push_back(rsp_vld_o);
        last_idle = idle_o;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < int'(NR); i++) begin
      if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      req_vld_i[i] = (src_q[i].size() != 0);
      req_data_i[i*16 +: 16] = (src_q[i].size() != 0) ? src_q[i][0] : 16'h0000;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en_i = 1'b0;
    for (int i = 0; i < int'(NR); i++) src_q[i].delete();
    req_vld_i  = '0;
    req_data_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (rsp_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("rsp_count", rsp_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lb;
    int unsigned rb;
    int unsigned n;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_sqrt_vld", 32'(sqrt_vld_o), 32'd0);
    chk("rst_sqrt_data", 32'(sqrt_data_o), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld_o), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);

    // Single request, operand register holds after the grant.
    en_i = 1'b1;
    src_q[0].push_back(16'h0010);
    tick();
    tick();
    chk("op_vld", 32'(sqrt_vld_o), 32'd1);
    chk("op_data", 32'(sqrt_data_o), 32'h0010);
    tick();
    chk("op_vld_drop", 32'(sqrt_vld_o), 32'd0);
    chk("op_hold", 32'(sqrt_data_o), 32'h0010);
    wait_rsp(1, 30);
    chk("t1_vld", 32'(rsp_vld_log[0]), 32'b0001);
    chk("t1_data", 32'(rsp_data_log[0]), 32'h040);

    // All four requesters continuously valid from pointer 0.
    do_reset();
    en_i = 1'b1;
    lb = acc_idx_log.size();
    rb = rsp_cnt;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < int'(NR); i++) src_q[i].push_back(16'($urandom));
    wait_rsp(rb + 12, 60);
    for (int k = 0; k < 8; k++) begin
      chk("rr_order", acc_idx_log[lb + k], 32'(k % 4));
      chk("rr_b2b", acc_cyc_log[lb + k] - acc_cyc_log[lb], 32'(k));
    end

    // Same requester back to back with extreme operands.
    rb = rsp_cnt;
    src_q[2].push_back(16'hFFFF);
    src_q[2].push_back(16'h0000);
    wait_rsp(rb + 2, 40);
    chk("t3_data0", 32'(rsp_data_log[rb]), 32'hFFF);
    chk("t3_data1", 32'(rsp_data_log[rb + 1]), 32'h000);
    chk("t3_vld0", 32'(rsp_vld_log[rb]), 32'b0100);
    chk("t3_vld1", 32'(rsp_vld_log[rb + 1]), 32'b0100);

    // Drop enable with five results in flight and one request still waiting.
    lb = acc_idx_log.size();
    rb = rsp_cnt;
    src_q[0].push_back(16'h0100);
    src_q[1].push_back(16'h0200);
    src_q[2].push_back(16'h0300);
    src_q[3].push_back(16'h0400);
    src_q[0].push_back(16'h0500);
    src_q[1].push_back(16'h0600);
    n = 0;
    while (acc_idx_log.size() < lb + 5 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_acc5", acc_idx_log.size(), lb + 5);
    en_i = 1'b0;
    tick();
    chk("drain_not_idle", 32'(idle_o), 32'd0);
    chk("drain_no_rdy", 32'(req_rdy_o), 32'd0);
    wait_rsp(rb + 5, 40);
    chk("drain_no_grant", acc_idx_log.size(), lb + 5);
    chk("drain_idle_at_last", 32'(last_idle), 32'd0);
    chk("drain_idle_after", 32'(idle_o), 32'd1);

    // Reset with results in flight: nothing may come back.
    en_i = 1'b1;
    lb = acc_idx_log.size();
    src_q[2].push_back(16'h1234);
    src_q[3].push_back(16'h0400);
    repeat (4) tick();
    chk("t5_acc", acc_idx_log.size(), lb + 3);
    rb = rsp_cnt;
    do_reset();
    repeat (30) tick();
    chk("t5_no_rsp", rsp_cnt, rb);
    chk("t5_rsp_vld", 32'(rsp_vld_o), 32'd0);
    chk("t5_err", 32'(err_o), 32'd0);

    // Spurious result with no tag.
    rb = rsp_cnt;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    tick();
    chk("spur_no_rsp", rsp_cnt, rb);
`ifdef SQRT_ARB_ERRCHK_EN
    chk("spur_err", 32'(err_o), 32'd1);
    repeat (5) tick();
    chk("spur_err_sticky", 32'(err_o), 32'd1);
    do_reset();
    chk("spur_err_clr", 32'(err_o), 32'd0);
`else
    chk("spur_err_off", 32'(err_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
